// File: rtl/signed_logic_resp_pkg.sv
// Shared definitions for the signed logic responder: operation select codes,
// default datapath width and the FIFO occupancy states.
package signed_logic_resp_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOT = 2'b11
  } logic_sel_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  function automatic fifo_state_e fill_state(input int unsigned fill,
                                             input int unsigned depth);
    if (fill == 0)          return FIFO_EMPTY;
    else if (fill >= depth) return FIFO_FULL;
    else                    return FIFO_PARTIAL;
  endfunction

endpackage

// File: rtl/signed_logic_resp_result_fifo.sv
// Small result queue with registered read/write pointers and a fill counter.
// The read data reads as zero while the queue is empty.
module result_fifo
  import signed_logic_resp_pkg::*;
#(
  parameter int unsigned W     = WIDTH_DEFAULT + 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [W-1:0]      mem_q [DEPTH];
  fifo_state_e       state;
  logic              do_push, do_pop;

  assign state   = fill_state(32'(fill_q), DEPTH);
  // Illegal push/pop requests are dropped so the pointers never move on them.
  assign do_push = push_i && (state != FIFO_FULL);
  assign do_pop  = pop_i  && (state != FIFO_EMPTY);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (state == FIFO_EMPTY) ? '0 : mem_q[rd_ptr_q];
  assign empty_o = (state == FIFO_EMPTY);
  assign full_o  = (state == FIFO_FULL);

endmodule

// File: rtl/signed_logic_resp.sv
// Handshaked responder for the signed logic unit: computes the bitwise result and
// flags at accept time, queues them, and counts accepted requests.
module signed_logic_resp
  import signed_logic_resp_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic [1:0]              in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_result,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic [CNT_W-1:0]        op_count
);

  logic [WIDTH-1:0] res;
  logic             res_zero, res_neg;
  logic             push, pop, fifo_empty, fifo_full;
  logic [WIDTH+1:0] head;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  always_comb begin
    res = '0;
    case (logic_sel_e'(in_sel))
      LOGIC_AND: res = in_a & in_b;
      LOGIC_OR:  res = in_a | in_b;
      LOGIC_XOR: res = in_a ^ in_b;
      LOGIC_NOT: res = ~in_a;
      default:   res = '0;
    endcase
  end

  assign res_zero = (res == '0);
  assign res_neg  = res[WIDTH-1];

  // in_ready comes only from the registered fill count, so a pop while full
  // cannot admit a push in the same cycle.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  result_fifo #(
    .W     (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({res_neg, res_zero, res}),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign out_result = head[WIDTH-1:0];
  assign out_zero   = head[WIDTH];
  assign out_neg    = head[WIDTH+1];

  always_comb begin
    op_count_d = op_count_q;
    if (push) op_count_d = op_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;

endmodule
